// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem reads and loads the IF/ID latch; a redirect
// that arrives during an outstanding imem read is parked until that read returns.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_WEN,
  input  logic        ifid_stall,
  input  logic        ifid_FLUSH,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_buf_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_npc_q;
  logic        ifid_valid_q;

  logic [31:0] redir_tgt_d;
  logic [31:0] pc_inc_d;
  logic        accept_d;

  always_comb begin
    redir_tgt_d = redirect_pc & ~32'h0000_0003;
    pc_inc_d    = pc_q + STEP;
    // Only a plain sequential fetch in FETCH delivers a word into IF/ID.
    accept_d    = (state_q == FETCH) && !halt && ihit && pc_WEN && !redirect_valid;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      redir_buf_q  <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_npc_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      if (ifid_FLUSH) begin
        ifid_instr_q <= 32'h0;
        ifid_npc_q   <= 32'h0;
        ifid_valid_q <= 1'b0;
      end else if (ifid_stall || state_q == HALTED) begin
        ifid_instr_q <= ifid_instr_q;
        ifid_npc_q   <= ifid_npc_q;
        ifid_valid_q <= ifid_valid_q;
      end else if (accept_d) begin
        ifid_instr_q <= imemload;
        ifid_npc_q   <= pc_inc_d;
        ifid_valid_q <= 1'b1;
      end else begin
        ifid_instr_q <= 32'h0;
        ifid_npc_q   <= 32'h0;
        ifid_valid_q <= 1'b0;
      end

      case (state_q)
        FETCH: begin
          if (halt) begin
            state_q <= HALTED;
          end else if (redirect_valid) begin
            if (ihit) begin
              pc_q <= redir_tgt_d;
            end else begin
              redir_buf_q <= redir_tgt_d;
              state_q     <= REDIR_PEND;
            end
          end else if (ihit && pc_WEN) begin
            pc_q <= pc_inc_d;
          end
        end
        REDIR_PEND: begin
          // The in-flight read must complete before the parked target is used.
          if (halt) begin
            state_q <= HALTED;
          end else begin
            if (redirect_valid) begin
              redir_buf_q <= redir_tgt_d;
            end
            if (ihit) begin
              pc_q    <= redirect_valid ? redir_tgt_d : redir_buf_q;
              state_q <= FETCH;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign imemREN      = (state_q != HALTED);
  assign imemaddr     = pc_q;
  assign fetch_halted = (state_q == HALTED);
  assign ifid_instr   = ifid_instr_q;
  assign ifid_npc     = ifid_npc_q;
  assign ifid_valid   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vectors for fetch_stage; expected post-edge outputs are queued per cycle
// and checked by an independent monitor.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pc_WEN = 1'b0;
  logic        ifid_stall = 1'b0;
  logic        ifid_FLUSH = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        fetch_halted;

  fetch_stage #(.PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
    .CLK(CLK), .RST(RST), .pc_WEN(pc_WEN), .ifid_stall(ifid_stall),
    .ifid_FLUSH(ifid_FLUSH), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        ren;
    logic        hlt;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 1ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "imemaddr",     imemaddr,             e.addr);
        chk(e.name, "imemREN",      {31'h0, imemREN},      {31'h0, e.ren});
        chk(e.name, "fetch_halted", {31'h0, fetch_halted}, {31'h0, e.hlt});
        chk(e.name, "ifid_valid",   {31'h0, ifid_valid},   {31'h0, e.vld});
        chk(e.name, "ifid_instr",   ifid_instr,           e.instr);
        chk(e.name, "ifid_npc",     ifid_npc,             e.npc);
      end
    end
  end

  // One cycle: drive inputs at the falling edge, queue the state expected after the next rising edge.
  task automatic step(input string name, input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic ih, input logic wen, input logic st, input logic fl,
                      input logic hl, input logic [31:0] load,
                      input logic [31:0] e_addr, input logic e_ren, input logic e_hlt,
                      input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_npc);
    exp_t e;
    @(negedge CLK);
    RST = rst; redirect_valid = rv; redirect_pc = rpc; ihit = ih; pc_WEN = wen;
    ifid_stall = st; ifid_FLUSH = fl; halt = hl; imemload = load;
    e.name = name; e.addr = e_addr; e.ren = e_ren; e.hlt = e_hlt;
    e.vld = e_vld; e.instr = e_instr; e.npc = e_npc;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name        rst rv rpc           ih wen st fl hl load            addr          ren hlt v  instr         npc
    step("reset",     1, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,          32'h0,        1,  0,  0, 32'h0,        32'h0);
    // Sequential fetch, one per cycle
    step("seq0",      0, 0, 32'h0,        1, 1,  0, 0, 0, 32'h1111_1111,  32'h4,        1,  0,  1, 32'h1111_1111, 32'h4);
    step("seq1",      0, 0, 32'h0,        1, 1,  0, 0, 0, 32'h2222_2222,  32'h8,        1,  0,  1, 32'h2222_2222, 32'h8);
    step("seq2",      0, 0, 32'h0,        1, 1,  0, 0, 0, 32'h3333_3333,  32'hC,        1,  0,  1, 32'h3333_3333, 32'hC);
    // Stall with pc_WEN=0 holds pc and IF/ID
    step("jmp3c",     0, 1, 32'h3C,       1, 1,  0, 0, 0, 32'hDEAD_0000,  32'h3C,       1,  0,  0, 32'h0,        32'h0);
    step("fet3c",     0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hAAAA_0001,  32'h40,       1,  0,  1, 32'hAAAA_0001, 32'h40);
    step("stall0",    0, 0, 32'h0,        1, 0,  1, 0, 0, 32'hBAD0_0000,  32'h40,       1,  0,  1, 32'hAAAA_0001, 32'h40);
    step("stall1",    0, 0, 32'h0,        1, 0,  1, 0, 0, 32'hBAD0_0001,  32'h40,       1,  0,  1, 32'hAAAA_0001, 32'h40);
    step("stall2",    0, 0, 32'h0,        1, 0,  1, 0, 0, 32'hBAD0_0002,  32'h40,       1,  0,  1, 32'hAAAA_0001, 32'h40);
    step("release",   0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hBBBB_0002,  32'h44,       1,  0,  1, 32'hBBBB_0002, 32'h44);
    // Redirect during a miss parks until ihit; target low bits dropped
    step("jmp10",     0, 1, 32'h10,       1, 1,  0, 0, 0, 32'hDEAD_0001,  32'h10,       1,  0,  0, 32'h0,        32'h0);
    step("pend0",     0, 1, 32'h203,      0, 1,  0, 0, 0, 32'hDEAD_0002,  32'h10,       1,  0,  0, 32'h0,        32'h0);
    step("pend1",     0, 0, 32'h0,        0, 1,  0, 0, 0, 32'hDEAD_0003,  32'h10,       1,  0,  0, 32'h0,        32'h0);
    step("pend2",     0, 0, 32'h0,        0, 1,  0, 0, 0, 32'hDEAD_0004,  32'h10,       1,  0,  0, 32'h0,        32'h0);
    step("pendhit",   0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hDEAD_0005,  32'h200,      1,  0,  0, 32'h0,        32'h0);
    step("fet200",    0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hCCCC_0003,  32'h204,      1,  0,  1, 32'hCCCC_0003, 32'h204);
    // Latest parked redirect wins, with and without same-cycle ihit
    step("ovr0",      0, 1, 32'h300,      0, 1,  0, 0, 0, 32'h0,          32'h204,      1,  0,  0, 32'h0,        32'h0);
    step("ovr1",      0, 1, 32'h502,      0, 1,  0, 0, 0, 32'h0,          32'h204,      1,  0,  0, 32'h0,        32'h0);
    step("ovrhit",    0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hDEAD_0006,  32'h500,      1,  0,  0, 32'h0,        32'h0);
    step("ovr2",      0, 1, 32'h604,      0, 1,  0, 0, 0, 32'h0,          32'h500,      1,  0,  0, 32'h0,        32'h0);
    step("ovr2hit",   0, 1, 32'h704,      1, 1,  0, 0, 0, 32'hDEAD_0007,  32'h704,      1,  0,  0, 32'h0,        32'h0);
    // Redirect + ihit + flush in the same cycle
    step("fet704",    0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hDDDD_0004,  32'h708,      1,  0,  1, 32'hDDDD_0004, 32'h708);
    step("rdflush",   0, 1, 32'h80,       1, 1,  0, 1, 0, 32'hDEAD_0008,  32'h80,       1,  0,  0, 32'h0,        32'h0);
    step("fet80",     0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hEEEE_0005,  32'h84,       1,  0,  1, 32'hEEEE_0005, 32'h84);
    step("flushstl",  0, 0, 32'h0,        0, 0,  1, 1, 0, 32'h0,          32'h84,       1,  0,  0, 32'h0,        32'h0);
    // PC wrap at top of address space
    step("jmptop",    0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 32'hDEAD_0009,  32'hFFFF_FFFC, 1, 0,  0, 32'h0,        32'h0);
    step("wrap",      0, 0, 32'h0,        1, 1,  0, 0, 0, 32'hFFFF_0006,  32'h0,        1,  0,  1, 32'hFFFF_0006, 32'h0);
    step("stallwen",  0, 0, 32'h0,        1, 1,  1, 0, 0, 32'h1234_5678,  32'h4,        1,  0,  1, 32'hFFFF_0006, 32'h0);
    // Halt dominates redirect; HALTED ignores inputs; reset recovers
    step("halt",      0, 1, 32'h900,      1, 1,  0, 0, 1, 32'hDEAD_000A,  32'h4,        0,  1,  0, 32'h0,        32'h0);
    step("halted0",   0, 1, 32'hA00,      1, 1,  0, 0, 0, 32'hDEAD_000B,  32'h4,        0,  1,  0, 32'h0,        32'h0);
    step("halted1",   0, 0, 32'h0,        1, 1,  0, 0, 1, 32'hDEAD_000C,  32'h4,        0,  1,  0, 32'h0,        32'h0);
    step("rsthalt",   1, 0, 32'h0,        1, 1,  0, 0, 0, 32'h0,          32'h0,        1,  0,  0, 32'h0,        32'h0);
    step("postrst",   0, 0, 32'h0,        1, 1,  0, 0, 0, 32'h7777_0007,  32'h4,        1,  0,  1, 32'h7777_0007, 32'h4);
    // Reset during a parked redirect discards it
    step("pend3",     0, 1, 32'hF00,      0, 1,  0, 0, 0, 32'h0,          32'h4,        1,  0,  0, 32'h0,        32'h0);
    step("rstpend",   1, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,          32'h0,        1,  0,  0, 32'h0,        32'h0);
    step("afterrst",  0, 0, 32'h0,        1, 1,  0, 0, 0, 32'h8888_0008,  32'h4,        1,  0,  1, 32'h8888_0008, 32'h4);

    @(negedge CLK);
    ihit = 1'b0; pc_WEN = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
